// File: rtl/destuff_ctrl.sv
// rtl/destuff_ctrl.sv - CAN receive destuffing sequencer
// Paces the bit destuffer per sample point and tracks frame fields SOF..TAIL.
module destuff_ctrl #(
  parameter int IDLE_BITS = 11,
  parameter int TAIL_BITS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       smplpnt,
  input  logic       sampledbit,
  input  logic       stuff,
  input  logic       stfer,
  input  logic       bitout,
  input  logic       frmabort,
  output logic       actvrstf,
  output logic       actvrdct,
  output logic       resetdst,
  output logic       bitvalid,
  output logic       bitdata,
  output logic       stuffbit,
  output logic       stferror,
  output logic       crcen,
  output logic [2:0] field,
  output logic [3:0] dlc
);

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0, F_SOF = 3'd1, F_ARB  = 3'd2, F_CTRL  = 3'd3,
    F_DATA  = 3'd4, F_CRC = 3'd5, F_TAIL = 3'd6, F_ERROR = 3'd7
  } field_e;

  field_e     field_q, field_d;
  logic [1:0] phase_q, phase_d;
  logic [6:0] cnt_q, cnt_d, len_q, len_d;
  logic [3:0] idle_q, idle_d, dlc_q, dlc_d;
  logic       ide_q, ide_d, rtr_q, rtr_d;
  logic       actvrstf_q, actvrstf_d, actvrdct_q, actvrdct_d, resetdst_q, resetdst_d;
  logic       bitvalid_q, bitvalid_d, bitdata_q, bitdata_d;
  logic       stuffbit_q, stuffbit_d, stferror_q, stferror_d, crcen_q, crcen_d;
  logic [3:0] dlc_new;
  logic [6:0] data_len, cnt_inc;

  always_comb begin
    dlc_new    = {dlc_q[2:0], bitout};
    data_len   = rtr_q ? 7'd0 : (dlc_new[3] ? 7'd64 : {1'b0, dlc_new[2:0], 3'b000});
    cnt_inc    = cnt_q + 7'd1;
    field_d    = field_q;
    phase_d    = (phase_q == 2'd0) ? 2'd0 : phase_q + 2'd1;
    cnt_d      = cnt_q;
    len_d      = len_q;
    idle_d     = idle_q;
    dlc_d      = dlc_q;
    ide_d      = ide_q;
    rtr_d      = rtr_q;
    actvrstf_d = 1'b0;
    bitvalid_d = 1'b0;
    bitdata_d  = bitdata_q;
    stuffbit_d = 1'b0;
    stferror_d = 1'b0;

    // phase 1..3 is the activ/update/eval window; new sample points are ignored inside it
    if (smplpnt && phase_q == 2'd0) begin
      if (field_q != F_IDLE) begin
        actvrstf_d = 1'b1;
        phase_d    = 2'd1;
      end else if (!sampledbit) begin
        actvrstf_d = 1'b1;
        phase_d    = 2'd1;
        field_d    = F_SOF;
        cnt_d      = 7'd0;
        ide_d      = 1'b0;
        rtr_d      = 1'b0;
      end
    end

    if (phase_q == 2'd3) begin
      case (field_q)
        F_SOF, F_ARB, F_CTRL, F_DATA, F_CRC: begin
          if (stfer) begin
            stferror_d = 1'b1;
            field_d    = F_ERROR;
            cnt_d      = 7'd0;
            idle_d     = 4'd0;
          end else if (stuff) begin
            stuffbit_d = 1'b1;
          end else begin
            bitvalid_d = 1'b1;
            bitdata_d  = bitout;
            cnt_d      = cnt_inc;
            case (field_q)
              F_SOF: begin
                field_d = F_ARB;
                cnt_d   = 7'd0;
              end
              F_ARB: begin
                // bit 12 is RTR (std) or SRR (ext); ext relatches RTR at bit 32
                if (cnt_q == 7'd11 || cnt_q == 7'd31) rtr_d = bitout;
                if (cnt_q == 7'd12) ide_d = bitout;
                if ((cnt_q == 7'd12 && !bitout) || cnt_q == 7'd31) begin
                  field_d = F_CTRL;
                  cnt_d   = 7'd0;
                end
              end
              F_CTRL: begin
                if (cnt_q >= (ide_q ? 7'd2 : 7'd1)) dlc_d = dlc_new;
                if (cnt_q == (ide_q ? 7'd5 : 7'd4)) begin
                  len_d   = data_len;
                  field_d = (data_len == 7'd0) ? F_CRC : F_DATA;
                  cnt_d   = 7'd0;
                end
              end
              F_DATA: begin
                if (cnt_inc == len_q) begin
                  field_d = F_CRC;
                  cnt_d   = 7'd0;
                end
              end
              default: begin
                if (cnt_q == 7'd14) begin
                  field_d = F_TAIL;
                  cnt_d   = 7'd0;
                end
              end
            endcase
          end
        end
        F_TAIL: begin
          bitvalid_d = 1'b1;
          bitdata_d  = bitout;
          if (cnt_q == 7'(TAIL_BITS - 1)) begin
            field_d = F_IDLE;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        F_ERROR: begin
          if (!bitout) begin
            idle_d = 4'd0;
          end else if (idle_q == 4'(IDLE_BITS - 1)) begin
            idle_d  = 4'd0;
            field_d = F_IDLE;
          end else begin
            idle_d = idle_q + 4'd1;
          end
        end
        default: ;
      endcase
    end

    // abort drops any bit in flight; a coincident stuff error keeps its strobe
    if (frmabort && field_q != F_IDLE) begin
      field_d    = F_ERROR;
      idle_d     = 4'd0;
      cnt_d      = 7'd0;
      phase_d    = 2'd0;
      actvrstf_d = 1'b0;
      bitvalid_d = 1'b0;
      stuffbit_d = 1'b0;
    end

    resetdst_d = (field_d != F_IDLE);
    actvrdct_d = (field_d == F_TAIL) || (field_d == F_ERROR);
    crcen_d    = (field_d == F_SOF) || (field_d == F_ARB) || (field_d == F_CTRL) || (field_d == F_DATA);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      field_q    <= F_IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= 7'd0;
      len_q      <= 7'd0;
      idle_q     <= 4'd0;
      dlc_q      <= 4'd0;
      ide_q      <= 1'b0;
      rtr_q      <= 1'b0;
      actvrstf_q <= 1'b0;
      actvrdct_q <= 1'b0;
      resetdst_q <= 1'b0;
      bitvalid_q <= 1'b0;
      bitdata_q  <= 1'b0;
      stuffbit_q <= 1'b0;
      stferror_q <= 1'b0;
      crcen_q    <= 1'b0;
    end else begin
      field_q    <= field_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      idle_q     <= idle_d;
      dlc_q      <= dlc_d;
      ide_q      <= ide_d;
      rtr_q      <= rtr_d;
      actvrstf_q <= actvrstf_d;
      actvrdct_q <= actvrdct_d;
      resetdst_q <= resetdst_d;
      bitvalid_q <= bitvalid_d;
      bitdata_q  <= bitdata_d;
      stuffbit_q <= stuffbit_d;
      stferror_q <= stferror_d;
      crcen_q    <= crcen_d;
    end
  end

  assign actvrstf = actvrstf_q;
  assign actvrdct = actvrdct_q;
  assign resetdst = resetdst_q;
  assign bitvalid = bitvalid_q;
  assign bitdata  = bitdata_q;
  assign stuffbit = stuffbit_q;
  assign stferror = stferror_q;
  assign crcen    = crcen_q;
  assign field    = field_q;
  assign dlc      = dlc_q;

endmodule

// File: tb/tb_destuff_ctrl.sv
// tb/tb_destuff_ctrl.sv - self-checking bench for destuff_ctrl
// Frames are built field by field, stuffed onto a bus, and a destuffer stand-in answers the DUT.
module tb_destuff_ctrl;

  localparam logic [2:0] F_IDLE = 3'd0, F_SOF = 3'd1, F_ARB = 3'd2, F_CTRL = 3'd3;
  localparam logic [2:0] F_DATA = 3'd4, F_CRC = 3'd5, F_TAIL = 3'd6, F_ERROR = 3'd7;

  logic clock = 1'b0, reset = 1'b1;
  logic smplpnt = 1'b0, sampledbit = 1'b1, frmabort = 1'b0, raw_bit = 1'b1;
  logic stuff_m = 1'b0, stfer_m = 1'b0, bitout_m = 1'b1;
  logic [2:0] run_cnt = 3'd0;
  logic run_val = 1'b0;
  logic actvrstf, actvrdct, resetdst, bitvalid, bitdata, stuffbit, stferror, crcen;
  logic [2:0] field;
  logic [3:0] dlc;

  typedef struct packed { logic d; logic [2:0] f; } exp_t;
  exp_t exp_q[$];
  bit   fbits[$];
  logic [2:0] ffld[$];
  bit   bus[$];
  bit   isstf[$];
  int   nstf_model = 0;
  int   n_err = 0, n_checks = 0, n_stuff_obs = 0, n_stfer_obs = 0;

  destuff_ctrl dut (
    .clock(clock), .reset(reset), .smplpnt(smplpnt), .sampledbit(sampledbit),
    .stuff(stuff_m), .stfer(stfer_m), .bitout(bitout_m), .frmabort(frmabort),
    .actvrstf(actvrstf), .actvrdct(actvrdct), .resetdst(resetdst), .bitvalid(bitvalid),
    .bitdata(bitdata), .stuffbit(stuffbit), .stferror(stferror), .crcen(crcen),
    .field(field), .dlc(dlc)
  );

  always #5 clock = ~clock;

  // destuffer stand-in: rule of five, bypass when direct, cleared while its reset is low
  always @(posedge clock) begin
    if (!resetdst) begin
      run_cnt <= 3'd0;
      run_val <= 1'b0;
      stuff_m <= 1'b0;
      stfer_m <= 1'b0;
    end else if (actvrstf) begin
      bitout_m <= raw_bit;
      if (actvrdct) begin
        stuff_m <= 1'b0;
        stfer_m <= 1'b0;
      end else if (run_cnt == 3'd5) begin
        stuff_m <= (raw_bit != run_val);
        stfer_m <= (raw_bit == run_val);
        run_val <= raw_bit;
        run_cnt <= 3'd1;
      end else begin
        stuff_m <= 1'b0;
        stfer_m <= 1'b0;
        if (run_cnt != 3'd0 && raw_bit == run_val) run_cnt <= run_cnt + 3'd1;
        else begin
          run_val <= raw_bit;
          run_cnt <= 3'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (stuffbit) n_stuff_obs++;
        if (stferror) n_stfer_obs++;
        if (bitvalid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL bitvalid_unexpected: actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            chk("bitdata", bitdata, e.d);
            chk("field", field, e.f);
            chk("crcen", crcen, (e.f >= F_SOF && e.f <= F_DATA));
            chk("actvrdct", actvrdct, (e.f == F_TAIL || e.f == F_ERROR));
            chk("resetdst", resetdst, (e.f != F_IDLE));
          end
        end
      end
    end
  end

  task automatic send_bit(input bit b, input bit timed);
    @(posedge clock); #1;
    raw_bit = b; sampledbit = b; smplpnt = 1'b1;
    @(posedge clock); #1;
    smplpnt = 1'b0;
    if (timed) begin
      chk("sof_actvrstf_t1", actvrstf, 1);
      chk("sof_field_t1", field, F_SOF);
      chk("sof_resetdst_t1", resetdst, 1);
    end
    for (int c = 2; c <= 6; c++) begin
      @(posedge clock); #1;
      if (timed && c == 2) chk("actvrstf_t2", actvrstf, 0);
      if (timed && c == 3) chk("bitvalid_t3", bitvalid, 0);
      if (timed && c == 4) chk("bitvalid_t4", bitvalid, 1);
      if (timed && c == 5) chk("bitvalid_t5", bitvalid, 0);
    end
  endtask

  task automatic fpush(input bit b, input logic [2:0] f);
    fbits.push_back(b);
    ffld.push_back(f);
  endtask

  task automatic load_frame(input bit ide, input logic [28:0] id, input bit rtr,
                            input logic [3:0] dlcv, input logic [63:0] data, input logic [14:0] crc);
    int nb, run;
    bit last;
    exp_t e;
    fbits.delete(); ffld.delete(); bus.delete(); isstf.delete();
    nstf_model = 0;
    fpush(1'b0, F_SOF);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) fpush(id[i], F_ARB);
      fpush(rtr, F_ARB); fpush(1'b0, F_ARB); fpush(1'b0, F_CTRL);
    end else begin
      for (int i = 28; i >= 18; i--) fpush(id[i], F_ARB);
      fpush(1'b1, F_ARB); fpush(1'b1, F_ARB);
      for (int i = 17; i >= 0; i--) fpush(id[i], F_ARB);
      fpush(rtr, F_ARB); fpush(1'b0, F_CTRL); fpush(1'b0, F_CTRL);
    end
    for (int i = 3; i >= 0; i--) fpush(dlcv[i], F_CTRL);
    nb = rtr ? 0 : ((dlcv > 4'd8) ? 8 : int'(dlcv));
    for (int i = 0; i < nb * 8; i++) fpush(data[63 - i], F_DATA);
    for (int i = 14; i >= 0; i--) fpush(crc[i], F_CRC);
    run = 0; last = 1'b0;
    for (int k = 0; k < fbits.size(); k++) begin
      bus.push_back(fbits[k]); isstf.push_back(1'b0);
      if (run > 0 && fbits[k] == last) run++;
      else begin last = fbits[k]; run = 1; end
      if (run == 5) begin
        bus.push_back(!last); isstf.push_back(1'b1);
        nstf_model++; last = !last; run = 1;
      end
    end
    for (int t = 0; t < 10; t++) begin bus.push_back(1'b1); isstf.push_back(1'b0); end
    for (int k = 0; k < fbits.size(); k++) begin
      e.d = fbits[k];
      e.f = (k + 1 < fbits.size()) ? ffld[k + 1] : F_TAIL;
      exp_q.push_back(e);
    end
    for (int t = 0; t < 10; t++) begin
      e.d = 1'b1;
      e.f = (t == 9) ? F_IDLE : F_TAIL;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] exp_dlc, input bit timed);
    n_stuff_obs = 0; n_stfer_obs = 0;
    for (int i = 0; i < bus.size(); i++) send_bit(bus[i], timed && i == 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_stuffbits"}, n_stuff_obs, nstf_model);
    chk({tag, "_stferror"}, n_stfer_obs, 0);
    chk({tag, "_field_idle"}, field, F_IDLE);
    chk({tag, "_resetdst"}, resetdst, 0);
    chk({tag, "_actvrdct"}, actvrdct, 0);
    chk({tag, "_dlc"}, dlc, exp_dlc);
  endtask

  task automatic recover(input string tag);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    chk({tag, "_still_error"}, field, F_ERROR);
    send_bit(1'b1, 1'b0);
    chk({tag, "_idle"}, field, F_IDLE);
    chk({tag, "_idle_resetdst"}, resetdst, 0);
    chk({tag, "_idle_actvrdct"}, actvrdct, 0);
  endtask

  initial begin
    exp_t e;
    int consumed;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_actvrstf", actvrstf, 0); chk("rst_actvrdct", actvrdct, 0);
    chk("rst_resetdst", resetdst, 0); chk("rst_bitvalid", bitvalid, 0);
    chk("rst_field", field, F_IDLE);  chk("rst_dlc", dlc, 0);
    reset = 1'b1;

    @(posedge clock); #1;
    sampledbit = 1'b1; raw_bit = 1'b1; smplpnt = 1'b1;
    @(posedge clock); #1;
    smplpnt = 1'b0;
    chk("idle_rec_actvrstf", actvrstf, 0);
    chk("idle_rec_field", field, F_IDLE);
    repeat (4) @(posedge clock);

    load_frame(1'b0, 29'h555, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 15'h2AAA);
    chk("f1_len", fbits.size(), 42);
    run_frame("f1", 4'd1, 1'b1);

    load_frame(1'b0, 29'h055, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 15'h2AAA);
    chk("f2_len", fbits.size(), 42);
    chk("f2_stuff_after_5th", isstf[5], 1);
    run_frame("f2", 4'd1, 1'b0);

    n_stuff_obs = 0; n_stfer_obs = 0;
    e.d = 1'b0; e.f = F_ARB; exp_q.push_back(e);
    e.d = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(e);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    chk("se_drained", exp_q.size(), 0);
    chk("se_stferror", n_stfer_obs, 1);
    chk("se_field", field, F_ERROR);
    chk("se_actvrdct", actvrdct, 1);
    chk("se_resetdst", resetdst, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    recover("se");

    load_frame(1'b1, 29'h0ABC_DEF1, 1'b1, 4'd8, 64'h0, 15'h2AAA);
    chk("ext_len", fbits.size(), 54);
    run_frame("ext", 4'd8, 1'b0);

    load_frame(1'b0, 29'h321, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h1555);
    chk("d15_len", fbits.size(), 98);
    run_frame("d15", 4'd15, 1'b0);

    load_frame(1'b0, 29'h321, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h1555);
    for (int i = 0; i < 40; i++) send_bit(bus[i], 1'b0);
    chk("ab_pre_field", field, F_DATA);
    consumed = 0;
    for (int i = 0; i < 40; i++) if (!isstf[i]) consumed++;
    @(posedge clock); #1;
    raw_bit = bus[40]; sampledbit = bus[40]; smplpnt = 1'b1; frmabort = 1'b1;
    @(posedge clock); #1;
    smplpnt = 1'b0;
    chk("ab_field", field, F_ERROR);
    chk("ab_actvrstf", actvrstf, 0);
    chk("ab_actvrdct", actvrdct, 1);
    repeat (6) @(posedge clock);
    #1 frmabort = 1'b0;
    chk("ab_left", exp_q.size(), fbits.size() + 10 - consumed);
    exp_q.delete();
    recover("ab");

    load_frame(1'b0, 29'h555, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 15'h2AAA);
    for (int i = 0; i < 33; i++) send_bit(bus[i], 1'b0);
    chk("rc_pre_field", field, F_CRC);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rc_actvrstf", actvrstf, 0); chk("rc_actvrdct", actvrdct, 0);
    chk("rc_resetdst", resetdst, 0); chk("rc_bitvalid", bitvalid, 0);
    chk("rc_bitdata", bitdata, 0);   chk("rc_stuffbit", stuffbit, 0);
    chk("rc_stferror", stferror, 0); chk("rc_crcen", crcen, 0);
    chk("rc_field", field, F_IDLE);  chk("rc_dlc", dlc, 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    e.d = 1'b0; e.f = F_ARB; exp_q.push_back(e);
    send_bit(1'b0, 1'b1);
    chk("rc_sof_drained", exp_q.size(), 0);
    chk("rc_field_arb", field, F_ARB);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
